// File: rtl/leb128_fetch.sv
`default_nettype none
// ============================================================================
// Module   : leb128_fetch
// Brief    : Fetches a ROM window and decodes one ULEB128/SLEB128 immediate.
// Revision : 1.0 - initial release
// ============================================================================
module leb128_fetch #(
   parameter int MEM_DEPTH = 4,
   parameter int MEM_EXTRA = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [MEM_DEPTH:0]              addr,
   input  logic                            is_signed,
   input  logic                            wide,
   output logic [MEM_DEPTH:0]              mem_addr,
   output logic [MEM_EXTRA-1:0]            mem_extra,
   input  logic [(2**MEM_EXTRA)*8-1:0]     mem_data,
   input  logic                            mem_error,
   output logic                            busy,
   output logic                            done,
   output logic [63:0]                     value,
   output logic [3:0]                      length,
   output logic [1:0]                      err
);

   localparam int                 c_WIN_BITS     = (2**MEM_EXTRA) * 8;
   localparam int                 c_SEL_W        = $clog2(c_WIN_BITS);
   localparam logic [MEM_EXTRA-1:0] c_EXTRA_WIDE   = MEM_EXTRA'(9);
   localparam logic [MEM_EXTRA-1:0] c_EXTRA_NARROW = MEM_EXTRA'(4);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [MEM_DEPTH:0]    r_addr;
   logic                  r_signed;
   logic                  r_wide;
   logic [c_WIN_BITS-1:0] r_window;
   logic [63:0]           r_acc;
   logic [6:0]            r_shift;
   logic [3:0]            r_count;
   logic [63:0]           r_value;
   logic [3:0]            r_length;
   logic [1:0]            r_err;
   logic                  r_done;

   logic [c_SEL_W-1:0]    w_bit_base;
   logic [7:0]            w_byte;
   logic [63:0]           w_acc_next;
   logic [6:0]            w_shift_next;
   logic [3:0]            w_count_next;
   logic [3:0]            w_max;
   logic [63:0]           w_sext;
   logic [63:0]           w_full;
   logic [63:0]           w_result;

   assign w_bit_base   = c_SEL_W'({r_count, 3'b000});
   assign w_byte       = r_window[w_bit_base +: 8];
   // Bits shifted past bit 63 fall off the 64-bit accumulator silently.
   assign w_acc_next   = r_acc | (64'(w_byte[6:0]) << r_shift);
   assign w_shift_next = r_shift + 7'd7;
   assign w_count_next = r_count + 4'd1;
   assign w_max        = r_wide ? 4'd10 : 4'd5;
   assign w_sext       = (r_signed && w_byte[6] && (w_shift_next < 7'd64)) ?
                         (~64'd0 << w_shift_next) : 64'd0;
   assign w_full       = w_acc_next | w_sext;
   assign w_result     = r_wide   ? w_full :
                         r_signed ? {{32{w_full[31]}}, w_full[31:0]} :
                                    {32'd0, w_full[31:0]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH:  w_next = S_WAIT;
         S_WAIT:   w_next = mem_error ? S_DONE : S_DECODE;
         S_DECODE: if (!w_byte[7] || (w_count_next == w_max)) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_signed <= 1'b0;
         r_wide   <= 1'b0;
         r_window <= '0;
         r_acc    <= '0;
         r_shift  <= '0;
         r_count  <= '0;
         r_value  <= '0;
         r_length <= '0;
         r_err    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next;
         // The pulse trails the DONE state so a start seen with it is accepted.
         r_done  <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr   <= addr;
                  r_signed <= is_signed;
                  r_wide   <= wide;
                  r_acc    <= '0;
                  r_shift  <= '0;
                  r_count  <= '0;
                  r_err    <= 2'b00;
               end
            end
            S_WAIT: begin
               if (mem_error) begin
                  r_err    <= 2'b01;
                  r_value  <= '0;
                  r_length <= r_count;
               end else begin
                  r_window <= mem_data;
               end
            end
            S_DECODE: begin
               r_acc   <= w_acc_next;
               r_shift <= w_shift_next;
               r_count <= w_count_next;
               if (!w_byte[7]) begin
                  r_value  <= w_result;
                  r_length <= w_count_next;
               end else if (w_count_next == w_max) begin
                  r_err    <= 2'b10;
                  r_value  <= '0;
                  r_length <= w_count_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign value     = r_value;
   assign length    = r_length;
   assign err       = r_err;
   assign mem_addr  = ((r_state == S_FETCH) || (r_state == S_WAIT)) ? r_addr : '0;
   assign mem_extra = ((r_state == S_FETCH) || (r_state == S_WAIT)) ?
                      (r_wide ? c_EXTRA_WIDE : c_EXTRA_NARROW) : '0;

endmodule
`default_nettype wire

// File: tb/tb_leb128_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_leb128_fetch
// Brief    : Directed self-checking bench for leb128_fetch with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leb128_fetch;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [4:0]   addr;
   logic         is_signed;
   logic         wide;
   logic [4:0]   mem_addr;
   logic [3:0]   mem_extra;
   logic [127:0] mem_data;
   logic         mem_error;
   logic         busy;
   logic         done;
   logic [63:0]  value;
   logic [3:0]   length;
   logic [1:0]   err;

   logic [7:0]   rom [0:63];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      mem_data = '0;
      for (int i = 0; i < 16; i++)
         mem_data[i*8 +: 8] = rom[6'({1'b0, mem_addr}) + 6'(i)];
   end

   leb128_fetch #(.MEM_DEPTH(4), .MEM_EXTRA(4)) dut (
      .clk(clk), .reset(reset), .start(start), .addr(addr),
      .is_signed(is_signed), .wide(wide), .mem_addr(mem_addr),
      .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error),
      .busy(busy), .done(done), .value(value), .length(length), .err(err)
   );

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 8'h00;
   endtask

   // Start is sampled at the edge this task waits for; returns #1 after it.
   task automatic launch(input logic [4:0] a, input logic s, input logic w);
      @(negedge clk);
      addr = a; is_signed = s; wide = w; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts rising edges until done is seen; -1 means it never came.
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1 lat++;
         if (done === 1'b1) return;
      end
      lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; addr = '0; is_signed = 1'b0; wide = 1'b0;
      mem_error = 1'b0;
      clear_rom();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (value !== 64'd0) begin errors++; $display("FAIL reset_value: got %h expected 0", value); end
      checks++; if (length !== 4'd0) begin errors++; $display("FAIL reset_length: got %0d expected 0", length); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
      checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
      checks++; if (mem_extra !== 4'd0) begin errors++; $display("FAIL reset_mem_extra: got %0d expected 0", mem_extra); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_uleb_narrow();
      int lat;
      clear_rom();
      rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26;
      launch(5'd0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy: got %b expected 1", busy); end
      checks++; if (mem_extra !== 4'd4) begin errors++; $display("FAIL fetch_extra_narrow: got %0d expected 4", mem_extra); end
      wait_done(lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL uleb_latency: got %0d expected 6", lat); end
      checks++; if (value !== 64'd624485) begin errors++; $display("FAIL uleb_value: got %0d expected 624485", value); end
      checks++; if (length !== 4'd3) begin errors++; $display("FAIL uleb_length: got %0d expected 3", length); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL uleb_err: got %b expected 00", err); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b expected 0", done); end
      checks++; if (value !== 64'd624485) begin errors++; $display("FAIL value_hold: got %0d expected 624485", value); end
   endtask

   task automatic test_sleb_wide();
      int lat;
      clear_rom();
      rom[3] = 8'h7F;
      launch(5'd3, 1'b1, 1'b1);
      checks++; if (mem_addr !== 5'd3) begin errors++; $display("FAIL fetch_addr: got %0d expected 3", mem_addr); end
      checks++; if (mem_extra !== 4'd9) begin errors++; $display("FAIL fetch_extra_wide: got %0d expected 9", mem_extra); end
      @(posedge clk); #1;
      checks++; if (mem_addr !== 5'd3) begin errors++; $display("FAIL wait_addr_hold: got %0d expected 3", mem_addr); end
      wait_done(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sleb_wide_latency: got %0d expected 3 (after one extra edge)", lat); end
      checks++; if (value !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sleb_wide_value: got %h expected ffffffffffffffff", value); end
      checks++; if (length !== 4'd1) begin errors++; $display("FAIL sleb_wide_length: got %0d expected 1", length); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL sleb_wide_err: got %b expected 00", err); end
   endtask

   task automatic test_sleb_narrow();
      int lat;
      clear_rom();
      rom[0] = 8'hC0; rom[1] = 8'hBB; rom[2] = 8'h78;
      launch(5'd0, 1'b1, 1'b0);
      wait_done(lat);
      checks++; if (value !== 64'hFFFF_FFFF_FFFE_1DC0) begin errors++; $display("FAIL sleb_narrow_value: got %h expected fffffffffffe1dc0", value); end
      checks++; if (length !== 4'd3) begin errors++; $display("FAIL sleb_narrow_length: got %0d expected 3", length); end
      launch(5'd0, 1'b0, 1'b0);
      wait_done(lat);
      checks++; if (value !== 64'h0000_0000_001E_1DC0) begin errors++; $display("FAIL uleb_zext_value: got %h expected 1e1dc0", value); end
   endtask

   task automatic test_wide_truncate();
      int lat;
      clear_rom();
      for (int i = 0; i < 9; i++) rom[i] = 8'hFF;
      rom[9] = 8'h7E;
      launch(5'd0, 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL trunc_latency: got %0d expected 13", lat); end
      checks++; if (value !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL trunc_value: got %h expected 7fffffffffffffff", value); end
      checks++; if (length !== 4'd10) begin errors++; $display("FAIL trunc_length: got %0d expected 10", length); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL trunc_err: got %b expected 00", err); end
   endtask

   task automatic test_mem_error();
      int lat;
      clear_rom();
      rom[0] = 8'h05;
      mem_error = 1'b1;
      launch(5'd0, 1'b0, 1'b0);
      wait_done(lat);
      mem_error = 1'b0;
      checks++; if (lat !== 3) begin errors++; $display("FAIL memerr_latency: got %0d expected 3", lat); end
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL memerr_err: got %b expected 01", err); end
      checks++; if (length !== 4'd0) begin errors++; $display("FAIL memerr_length: got %0d expected 0", length); end
      checks++; if (value !== 64'd0) begin errors++; $display("FAIL memerr_value: got %h expected 0", value); end
      @(posedge clk); #1;
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL memerr_hold: got %b expected 01", err); end
      launch(5'd0, 1'b0, 1'b0);
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL err_clear_on_start: got %b expected 00", err); end
      wait_done(lat);
      checks++; if (value !== 64'd5) begin errors++; $display("FAIL after_memerr_value: got %0d expected 5", value); end
   endtask

   task automatic test_overflow();
      int lat;
      clear_rom();
      for (int i = 0; i < 11; i++) rom[i] = 8'h80;
      launch(5'd0, 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL ovf_wide_latency: got %0d expected 13", lat); end
      checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_wide_err: got %b expected 10", err); end
      checks++; if (length !== 4'd10) begin errors++; $display("FAIL ovf_wide_length: got %0d expected 10", length); end
      checks++; if (value !== 64'd0) begin errors++; $display("FAIL ovf_wide_value: got %h expected 0", value); end
      launch(5'd0, 1'b1, 1'b0);
      wait_done(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL ovf_narrow_latency: got %0d expected 8", lat); end
      checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_narrow_err: got %b expected 10", err); end
      checks++; if (length !== 4'd5) begin errors++; $display("FAIL ovf_narrow_length: got %0d expected 5", length); end
   endtask

   task automatic test_mem_error_ignored();
      int lat;
      clear_rom();
      rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26;
      launch(5'd0, 1'b0, 1'b0);
      mem_error = 1'b1;
      @(negedge clk);
      mem_error = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 mem_error = 1'b1;
      wait_done(lat);
      mem_error = 1'b0;
      checks++; if (lat !== 4) begin errors++; $display("FAIL memerr_ign_latency: got %0d expected 4", lat); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL memerr_ign_err: got %b expected 00", err); end
      checks++; if (value !== 64'd624485) begin errors++; $display("FAIL memerr_ign_value: got %0d expected 624485", value); end
   endtask

   task automatic test_back_to_back();
      int lat;
      clear_rom();
      rom[0] = 8'h05; rom[1] = 8'h06;
      // start while busy is dropped
      launch(5'd0, 1'b0, 1'b0);
      @(negedge clk);
      addr = 5'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL busy_start_latency: got %0d expected 3", lat); end
      checks++; if (value !== 64'd5) begin errors++; $display("FAIL busy_start_value: got %0d expected 5", value); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got %b expected 0", busy); end
      // start during the DONE state is dropped
      launch(5'd0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      addr = 5'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_state_pulse: got %b expected 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_state_start: got %b expected 0", busy); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_state_queued: got %b expected 0", busy); end
      // start alongside the done pulse is accepted
      launch(5'd0, 1'b0, 1'b0);
      wait_done(lat);
      addr = 5'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
      checks++; if (mem_addr !== 5'd1) begin errors++; $display("FAIL b2b_addr: got %0d expected 1", mem_addr); end
      wait_done(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
      checks++; if (value !== 64'd6) begin errors++; $display("FAIL b2b_value: got %0d expected 6", value); end
   endtask

   task automatic test_reset_mid_decode();
      int lat;
      clear_rom();
      for (int i = 0; i < 11; i++) rom[i] = 8'h80;
      launch(5'd0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
      checks++; if (value !== 64'd0) begin errors++; $display("FAIL midrst_value: got %h expected 0", value); end
      checks++; if (length !== 4'd0) begin errors++; $display("FAIL midrst_length: got %0d expected 0", length); end
      checks++; if (mem_extra !== 4'd0) begin errors++; $display("FAIL midrst_extra: got %0d expected 0", mem_extra); end
      @(negedge clk);
      reset = 1'b1;
      clear_rom();
      rom[0] = 8'h02;
      launch(5'd0, 1'b0, 1'b0);
      wait_done(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL postrst_latency: got %0d expected 4", lat); end
      checks++; if (value !== 64'd2) begin errors++; $display("FAIL postrst_value: got %0d expected 2", value); end
      checks++; if (length !== 4'd1) begin errors++; $display("FAIL postrst_length: got %0d expected 1", length); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL postrst_err: got %b expected 00", err); end
   endtask

   initial begin
      test_reset();
      test_uleb_narrow();
      test_sleb_wide();
      test_sleb_narrow();
      test_wide_truncate();
      test_mem_error();
      test_overflow();
      test_mem_error_ignored();
      test_back_to_back();
      test_reset_mid_decode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
